// File: rtl/vga_plot_unit.sv
`default_nettype none
// ============================================================================
// Module   : vga_plot_unit
// Purpose  : Captures plot requests (colour + packed x/y coordinate), buffers
//            them in a small FIFO and replays them into a 160x120, 3-bit VGA
//            adapter write port at one pixel per cycle. Also runs a
//            full-screen clear sweep on request.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clock        in   system clock, rising edge
//   reset        in   asynchronous active-high reset
//   plot         in   single-cycle pixel request
//   color_value  in   [2:0] = pixel colour
//   coord_value  in   [15:8] = x, [7:0] = y
//   clear        in   single-cycle full-screen fill request
//   clear_color  in   fill colour, sampled when clear is taken
//   vga_x/y/colour/writeEn  out  adapter write port (registered)
//   busy         out  FIFO non-empty, sweeping, or a write in flight
//   full         out  FIFO holds FIFO_DEPTH entries
//   overflow     out  sticky, a request was dropped on a full FIFO
//   range_error  out  sticky, a request had an off-screen coordinate
// ============================================================================
module vga_plot_unit #(
    parameter int FIFO_DEPTH = 4,
    parameter int SCREEN_W   = 160,
    parameter int SCREEN_H   = 120
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        plot,
    input  logic [15:0] color_value,
    input  logic [15:0] coord_value,
    input  logic        clear,
    input  logic [2:0]  clear_color,
    output logic [7:0]  vga_x,
    output logic [6:0]  vga_y,
    output logic [2:0]  vga_colour,
    output logic        vga_writeEn,
    output logic        busy,
    output logic        full,
    output logic        overflow,
    output logic        range_error
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] c_depth   = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
    localparam logic [PTR_W-1:0] c_ptr_one = PTR_W'(1);
    localparam logic [8:0]       c_w       = 9'(SCREEN_W);
    localparam logic [8:0]       c_h       = 9'(SCREEN_H);
    localparam logic [7:0]       c_x_last  = 8'(SCREEN_W - 1);
    localparam logic [6:0]       c_y_last  = 7'(SCREEN_H - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t           state_q,       state_d;
    logic [7:0]       sx_q,          sx_d;
    logic [6:0]       sy_q,          sy_d;
    logic [2:0]       fill_q,        fill_d;
    logic [PTR_W-1:0] wr_ptr_q,      wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q,      rd_ptr_d;
    logic [CNT_W-1:0] count_q,       count_d;
    logic [7:0]       x_q,           x_d;
    logic [6:0]       y_q,           y_d;
    logic [2:0]       colour_q,      colour_d;
    logic             we_q,          we_d;
    logic             busy_q,        busy_d;
    logic             full_q,        full_d;
    logic             overflow_q,    overflow_d;
    logic             range_err_q,   range_err_d;

    // Entry layout: {x[7:0], y[6:0], colour[2:0]}
    logic [17:0]      mem [FIFO_DEPTH];

    logic             w_in_range;
    logic             w_pop;
    logic             w_push;
    logic [17:0]      w_entry;
    logic [17:0]      w_head;
    logic             w_unused_color;

    assign w_unused_color = ^color_value[15:3];

    always_comb begin
        w_in_range = ({1'b0, coord_value[15:8]} < c_w) &&
                     ({1'b0, coord_value[7:0]}  < c_h);
        // A clear request claims the cycle, so the head stays queued.
        w_pop      = (state_q == ST_IDLE) && !clear && (count_q != '0);
        // A full FIFO still accepts when the head leaves in the same cycle.
        w_push     = plot && w_in_range && ((count_q != c_depth) || w_pop);
        w_entry    = {coord_value[15:8], coord_value[6:0], color_value[2:0]};
        w_head     = mem[rd_ptr_q];

        state_d     = state_q;
        sx_d        = sx_q;
        sy_d        = sy_q;
        fill_d      = fill_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        x_d         = x_q;
        y_d         = y_q;
        colour_d    = colour_q;
        we_d        = 1'b0;
        overflow_d  = overflow_q;
        range_err_d = range_err_q;

        if (clear) begin
            // Start (or restart) the sweep; first pixel is emitted next edge.
            state_d = ST_CLEAR;
            sx_d    = '0;
            sy_d    = '0;
            fill_d  = clear_color;
        end else if (state_q == ST_CLEAR) begin
            x_d      = sx_q;
            y_d      = sy_q;
            colour_d = fill_q;
            we_d     = 1'b1;
            if (sx_q == c_x_last) begin
                sx_d = '0;
                if (sy_q == c_y_last) begin
                    sy_d    = '0;
                    state_d = ST_IDLE;
                end else begin
                    sy_d = sy_q + 7'd1;
                end
            end else begin
                sx_d = sx_q + 8'd1;
            end
        end else if (w_pop) begin
            {x_d, y_d, colour_d} = w_head;
            we_d     = 1'b1;
            rd_ptr_d = rd_ptr_q + c_ptr_one;
        end

        if (w_push) begin
            wr_ptr_d = wr_ptr_q + c_ptr_one;
        end

        case ({w_push, w_pop})
            2'b10:   count_d = count_q + c_cnt_one;
            2'b01:   count_d = count_q - c_cnt_one;
            default: count_d = count_q;
        endcase

        if (plot && !w_in_range) begin
            range_err_d = 1'b1;
        end
        if (plot && w_in_range && (count_q == c_depth) && !w_pop) begin
            overflow_d = 1'b1;
        end

        full_d = (count_d == c_depth);
        busy_d = (count_d != '0) || (state_d == ST_CLEAR) || we_d;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            sx_q        <= '0;
            sy_q        <= '0;
            fill_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            x_q         <= '0;
            y_q         <= '0;
            colour_q    <= '0;
            we_q        <= 1'b0;
            busy_q      <= 1'b0;
            full_q      <= 1'b0;
            overflow_q  <= 1'b0;
            range_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sx_q        <= sx_d;
            sy_q        <= sy_d;
            fill_q      <= fill_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            x_q         <= x_d;
            y_q         <= y_d;
            colour_q    <= colour_d;
            we_q        <= we_d;
            busy_q      <= busy_d;
            full_q      <= full_d;
            overflow_q  <= overflow_d;
            range_err_q <= range_err_d;
        end
    end

    // Storage needs no reset: the count and pointers define what is valid.
    always_ff @(posedge clock) begin
        if (w_push) begin
            mem[wr_ptr_q] <= w_entry;
        end
    end

    assign vga_x       = x_q;
    assign vga_y       = y_q;
    assign vga_colour  = colour_q;
    assign vga_writeEn = we_q;
    assign busy        = busy_q;
    assign full        = full_q;
    assign overflow    = overflow_q;
    assign range_error = range_err_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_plot_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_plot_unit
// Purpose  : Self-checking bench for vga_plot_unit. A queue/index based
//            reference model predicts every output each cycle; directed
//            scenarios add targeted checks on top.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_plot_unit;

    localparam int D = 4;
    localparam int W = 160;
    localparam int H = 120;

    logic        clock = 1'b0;
    logic        reset;
    logic        plot;
    logic        clear;
    logic [15:0] color_value;
    logic [15:0] coord_value;
    logic [2:0]  clear_color;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_writeEn;
    logic        busy;
    logic        full;
    logic        overflow;
    logic        range_error;

    vga_plot_unit #(
        .FIFO_DEPTH (D),
        .SCREEN_W   (W),
        .SCREEN_H   (H)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .plot        (plot),
        .color_value (color_value),
        .coord_value (coord_value),
        .clear       (clear),
        .clear_color (clear_color),
        .vga_x       (vga_x),
        .vga_y       (vga_y),
        .vga_colour  (vga_colour),
        .vga_writeEn (vga_writeEn),
        .busy        (busy),
        .full        (full),
        .overflow    (overflow),
        .range_error (range_error)
    );

    always #5 clock = ~clock;

    logic [22:0] dut_vec;
    assign dut_vec = {vga_writeEn, vga_x, vga_y, vga_colour,
                      busy, full, overflow, range_error};

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int mq[$];          // queued pixels, x*65536 + y*256 + c
    bit m_clearing;
    int m_idx;          // linear sweep position 0..W*H-1
    int m_cc;
    int m_we, m_x, m_y, m_c;
    bit m_ovf, m_rerr;

    task automatic model_reset();
        mq.delete();
        m_clearing = 0;
        m_idx = 0;
        m_cc = 0;
        m_we = 0; m_x = 0; m_y = 0; m_c = 0;
        m_ovf = 0; m_rerr = 0;
    endtask

    task automatic model_edge();
        int  ix, iy, sz, e;
        bit  pop;
        if (reset) begin
            model_reset();
            return;
        end
        ix  = int'(coord_value[15:8]);
        iy  = int'(coord_value[7:0]);
        sz  = mq.size();
        pop = !m_clearing && !clear && (sz > 0);
        m_we = 0;
        if (clear) begin
            m_clearing = 1;
            m_idx = 0;
            m_cc = int'(clear_color);
        end else if (m_clearing) begin
            m_we = 1;
            m_x = m_idx % W;
            m_y = m_idx / W;
            m_c = m_cc;
            m_idx++;
            if (m_idx == W * H) m_clearing = 0;
        end else if (pop) begin
            e = mq.pop_front();
            m_we = 1;
            m_x = e / 65536;
            m_y = (e / 256) % 256;
            m_c = e % 256;
        end
        if (plot) begin
            if (ix >= W || iy >= H) m_rerr = 1;
            else if (sz < D || pop) mq.push_back(ix * 65536 + iy * 256 + int'(color_value[2:0]));
            else m_ovf = 1;
        end
    endtask

    function automatic logic [22:0] model_vec();
        logic b, f;
        logic [7:0] x8;
        logic [6:0] y7;
        logic [2:0] c3;
        b  = (mq.size() != 0) || m_clearing || (m_we != 0);
        f  = (mq.size() == D);
        x8 = 8'(m_x);
        y7 = 7'(m_y);
        c3 = 3'(m_c);
        return {(m_we != 0), x8, y7, c3, b, f, m_ovf, m_rerr};
    endfunction

    // ---------------- stimulus helpers ----------------
    logic [17:0] log_e[$];
    int          log_cyc[$];
    int          cyc = 0;

    task automatic step();
        @(posedge clock);
        model_edge();
        cyc++;
        #1;
        check("outs", 32'(dut_vec), 32'(model_vec()));
        if (vga_writeEn === 1'b1) begin
            log_e.push_back({vga_x, vga_y, vga_colour});
            log_cyc.push_back(cyc);
        end
    endtask

    task automatic clear_log();
        log_e.delete();
        log_cyc.delete();
    endtask

    task automatic run_until_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 25000) begin
            step();
            n++;
        end
        if (busy !== 1'b0) check("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic start_clear(input logic [2:0] col);
        clear_color = col;
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic do_plot(input logic [7:0] x, input logic [7:0] y,
                           input logic [2:0] c);
        coord_value = {x, y};
        color_value = {13'd0, c};
        plot = 1'b1;
        step();
        plot = 1'b0;
    endtask

    initial begin
        logic [17:0] e;
        int bad;
        int n;
        reset = 1'b1; plot = 1'b0; clear = 1'b0;
        color_value = '0; coord_value = '0; clear_color = '0;
        model_reset();
        step();
        step();
        check("reset_outs", 32'(dut_vec), 32'd0);
        reset = 1'b0;

        // Single plot latency and value
        do_plot(8'd10, 8'd5, 3'd6);
        check("t1_we_push_edge", 32'(vga_writeEn), 32'd0);
        step();
        check("t1_we", 32'(vga_writeEn), 32'd1);
        check("t1_pixel", 32'({vga_x, vga_y, vga_colour}), 32'({8'd10, 7'd5, 3'd6}));
        step();
        check("t1_we_off", 32'(vga_writeEn), 32'd0);
        check("t1_busy_off", 32'(busy), 32'd0);

        // Randomized plotting, including off-screen coordinates
        for (int i = 0; i < 1500; i++) begin
            plot        = ($urandom_range(0, 3) != 0);
            coord_value = {8'($urandom_range(0, 170)), 8'($urandom_range(0, 127))};
            color_value = 16'($urandom);
            step();
        end
        plot = 1'b0;
        pulse_reset();

        // Back-to-back plots during a sweep: 4 stored, 2 dropped
        clear_log();
        start_clear(3'd2);
        for (int i = 0; i < 6; i++) begin
            do_plot(8'(i), 8'd0, 3'd1);
            if (i == 3) check("t2_full", 32'(full), 32'd1);
        end
        check("t2_overflow", 32'(overflow), 32'd1);
        run_until_idle();
        check("t2_nwrites", 32'(log_e.size()), 32'(W * H + 4));
        if (log_e.size() >= W * H + 4) begin
            for (int k = 0; k < 4; k++) begin
                e = log_e[W * H + k];
                check("t2_drain_px", 32'(e), 32'({8'(k), 7'd0, 3'd1}));
            end
        end

        // Off-screen coordinates
        pulse_reset();
        clear_log();
        coord_value = 16'hA000; color_value = 16'd1; plot = 1'b1; step();
        coord_value = 16'h0078; step();
        plot = 1'b0;
        repeat (4) step();
        check("t3_nwrites", 32'(log_e.size()), 32'd0);
        check("t3_range_error", 32'(range_error), 32'd1);
        check("t3_overflow", 32'(overflow), 32'd0);
        check("t3_busy", 32'(busy), 32'd0);
        check("t3_full", 32'(full), 32'd0);

        // Full sweep
        clear_log();
        start_clear(3'd3);
        run_until_idle();
        check("t4_nwrites", 32'(log_e.size()), 32'(W * H));
        if (log_e.size() == W * H) begin
            e = log_e[0];
            check("t4_first", 32'(e), 32'({8'd0, 7'd0, 3'd3}));
            e = log_e[W * H - 1];
            check("t4_last", 32'(e), 32'({8'd159, 7'd119, 3'd3}));
            bad = 0;
            foreach (log_e[i]) begin
                e = log_e[i];
                if (e[2:0] != 3'd3) bad++;
            end
            check("t4_colour_errs", 32'(bad), 32'd0);
            check("t4_contiguous", 32'(log_cyc[W * H - 1] - log_cyc[0] + 1), 32'(W * H));
            check("t4_busy_drop", 32'(cyc - log_cyc[W * H - 1]), 32'd1);
        end

        // Restart a sweep part-way through
        start_clear(3'd4);
        repeat (500) step();
        clear_log();
        start_clear(3'd5);
        run_until_idle();
        check("t5_nwrites", 32'(log_e.size()), 32'(W * H));
        if (log_e.size() == W * H) begin
            e = log_e[0];
            check("t5_first", 32'(e), 32'({8'd0, 7'd0, 3'd5}));
            e = log_e[W * H - 1];
            check("t5_last", 32'(e), 32'({8'd159, 7'd119, 3'd5}));
        end

        // Asynchronous reset in the middle of a drain
        pulse_reset();
        start_clear(3'd0);
        for (int i = 0; i < 5; i++) do_plot(8'(20 + i), 8'd7, 3'd2);
        check("t6_overflow_set", 32'(overflow), 32'd1);
        n = 0;
        while (!(vga_writeEn === 1'b1 && vga_x == 8'd20) && n < 25000) begin
            step();
            n++;
        end
        check("t6_first_drain_x", 32'(vga_x), 32'd20);
        check("t6_busy_before", 32'(busy), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("t6_async_zero", 32'(dut_vec), 32'd0);
        model_reset();
        step();
        step();
        reset = 1'b0;
        clear_log();
        repeat (10) step();
        check("t6_nwrites", 32'(log_e.size()), 32'd0);
        check("t6_full", 32'(full), 32'd0);
        check("t6_overflow", 32'(overflow), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
